gpio_bank_prog_ctrl: RTL and testbench

GPIO_BANK_PROG_CTRL -- requirements
Module: gpio_bank_prog_ctrl

---
 rtl/gpio_bank_prog_ctrl.sv | 131 +++++++++++++
 tb/tb_gpio_bank_prog_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_prog_ctrl.sv
// Programming controller for one SRAM config bank: accepts row writes and
// sequences data setup, a timed wordline pulse and data hold for each row.
module gpio_bank_prog_ctrl #(
    parameter int NUM_BL   = 4,
    parameter int NUM_WL   = 4,
    parameter int WL_PULSE = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [7:0]        cfg_addr,
    input  logic [NUM_BL-1:0] cfg_data,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic [8:0]        wr_count,
    output logic              addr_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int              ADDR_W   = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
    localparam logic [8:0]      NUM_WL_9 = 9'(NUM_WL);
    localparam logic [NUM_WL-1:0] WL_ONE = NUM_WL'(1);
    localparam logic [3:0]      CNT_LOAD = 4'(WL_PULSE - 1);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [NUM_BL-1:0] data_q,     data_d;
    logic [3:0]        cnt_q,      cnt_d;
    logic [NUM_BL-1:0] bl_q,       bl_d;
    logic [NUM_WL-1:0] wl_q,       wl_d;
    logic              busy_q,     busy_d;
    logic [8:0]        wr_count_q, wr_count_d;
    logic              addr_err_q, addr_err_d;
    logic              handshake;
    logic              addr_ok;

    assign cfg_ready = (state_q == IDLE);
    assign handshake = cfg_valid && cfg_ready;
    assign addr_ok   = ({1'b0, cfg_addr} < NUM_WL_9);

    // Output registers are loaded with the value the next state will present,
    // so bl/wl/busy switch on the same edge as the state they belong to.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        bl_d       = bl_q;
        wl_d       = wl_q;
        busy_d     = busy_q;
        wr_count_d = wr_count_q;
        addr_err_d = addr_err_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (addr_ok) begin
                        addr_d  = cfg_addr[ADDR_W-1:0];
                        data_d  = cfg_data;
                        bl_d    = cfg_data;
                        busy_d  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                wl_d    = WL_ONE << addr_q;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    wl_d    = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                bl_d    = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (wr_count_q != 9'd511) begin
                    wr_count_d = wr_count_q + 9'd1;
                end
            end
        endcase
    end

    // NOTE: async reset clears every flop so an aborted pulse drops wl at once.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            bl_q       <= '0;
            wl_q       <= '0;
            busy_q     <= 1'b0;
            wr_count_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from old values.
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            bl_q       <= bl_d;
            wl_q       <= wl_d;
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bl       = bl_q;
    assign wl       = wl_q;
    assign busy     = busy_q;
    assign wr_count = wr_count_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_gpio_bank_prog_ctrl.sv
// Randomized self-checking bench: a write-timeline model predicts every output
// cycle by cycle; a second instance covers the single-cycle pulse build.
module tb_gpio_bank_prog_ctrl;

    localparam int NUM_BL   = 4;
    localparam int NUM_WL   = 4;
    localparam int WL_PULSE = 2;

    logic        prog_clk = 1'b0;
    logic        prog_reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [3:0]  cfg_data = '0;
    logic        cfg_ready;
    logic [3:0]  bl;
    logic [3:0]  wl;
    logic        busy;
    logic [8:0]  wr_count;
    logic        addr_err;

    logic        c1_valid = 1'b0;
    logic [7:0]  c1_addr = '0;
    logic [3:0]  c1_data = '0;
    logic        c1_ready;
    logic [3:0]  bl1;
    logic [3:0]  wl1;
    logic        busy1;
    logic [8:0]  wr_count1;
    logic        addr_err1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model: offset of the current cycle within a write (0 = idle).
    int         m_offs = 0;
    int         m_addr = 0;
    logic [3:0] m_data = '0;
    int         m_count = 0;
    logic       m_err = 1'b0;

    always #5 prog_clk = ~prog_clk;

    gpio_bank_prog_ctrl #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .WL_PULSE(WL_PULSE)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .bl(bl), .wl(wl), .busy(busy), .wr_count(wr_count), .addr_err(addr_err)
    );

    gpio_bank_prog_ctrl #(.NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .WL_PULSE(1)) dut1 (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n),
        .cfg_valid(c1_valid), .cfg_ready(c1_ready),
        .cfg_addr(c1_addr), .cfg_data(c1_data),
        .bl(bl1), .wl(wl1), .busy(busy1), .wr_count(wr_count1), .addr_err(addr_err1)
    );

    function automatic logic [3:0] exp_bl();
        return (m_offs == 0) ? 4'b0000 : m_data;
    endfunction

    function automatic logic [3:0] exp_wl();
        if (m_offs >= 2 && m_offs <= WL_PULSE + 1) return 4'(1 << m_addr);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_offs  = 0;
        m_addr  = 0;
        m_data  = '0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    // One clock of stimulus on the main instance, with model update and checks.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [3:0] d,
                         output logic hs);
        @(negedge prog_clk);
        cfg_valid = v;
        cfg_addr  = a;
        cfg_data  = d;
        #1;
        n_vec++;
        if (cfg_ready !== (m_offs == 0)) begin
            n_bad++;
            $display("FAIL ready cyc=%0d got %b want %b", cyc, cfg_ready, (m_offs == 0));
        end
        hs = v && (m_offs == 0);
        @(posedge prog_clk);
        cyc++;
        if (m_offs == 0) begin
            if (v) begin
                if (a < NUM_WL) begin
                    m_offs = 1;
                    m_addr = int'(a);
                    m_data = d;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_offs == WL_PULSE + 2) begin
            m_offs = 0;
            if (m_count < 511) m_count++;
        end else begin
            m_offs++;
        end
        #1;
        n_vec++;
        if (bl !== exp_bl() || wl !== exp_wl() || busy !== (m_offs != 0) ||
            wr_count !== 9'(m_count) || addr_err !== m_err) begin
            n_bad++;
            $display("FAIL outputs cyc=%0d got bl=%b wl=%b busy=%b cnt=%0d err=%b want bl=%b wl=%b busy=%b cnt=%0d err=%b",
                     cyc, bl, wl, busy, wr_count, addr_err,
                     exp_bl(), exp_wl(), (m_offs != 0), m_count, m_err);
        end
    endtask

    task automatic do_reset();
        @(negedge prog_clk);
        cfg_valid    = 1'b0;
        c1_valid     = 1'b0;
        prog_reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (bl !== 4'b0 || wl !== 4'b0 || busy !== 1'b0 || wr_count !== 9'd0 ||
            addr_err !== 1'b0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_values got bl=%b wl=%b busy=%b cnt=%0d err=%b rdy=%b want all zero, rdy=1",
                     bl, wl, busy, wr_count, addr_err, cfg_ready);
        end
        repeat (2) @(negedge prog_clk);
        prog_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic hs;
        do_reset();
        cycle(1'b0, 8'd0, 4'd0, hs);
    endtask

    task automatic test_single_write();
        logic hs;
        do_reset();
        cycle(1'b1, 8'd2, 4'b1011, hs);
        n_vec++;
        if (bl !== 4'b1011 || wl !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_setup got bl=%b wl=%b want 1011/0000", bl, wl);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'd0, 4'd0, hs);
            n_vec++;
            if (wl !== 4'b0100 || bl !== 4'b1011) begin
                n_bad++;
                $display("FAIL single_pulse%0d got bl=%b wl=%b want 1011/0100", i, bl, wl);
            end
        end
        cycle(1'b0, 8'd0, 4'd0, hs);
        n_vec++;
        if (wl !== 4'b0000 || bl !== 4'b1011) begin
            n_bad++;
            $display("FAIL single_hold got bl=%b wl=%b want 1011/0000", bl, wl);
        end
        cycle(1'b0, 8'd0, 4'd0, hs);
        n_vec++;
        if (bl !== 4'b0000 || cfg_ready !== 1'b1 || wr_count !== 9'd1) begin
            n_bad++;
            $display("FAIL single_done got bl=%b rdy=%b cnt=%0d want 0000/1/1", bl, cfg_ready, wr_count);
        end
    endtask

    task automatic test_back_to_back();
        logic hs;
        int   k = 0;
        int   last = -1;
        do_reset();
        for (int i = 0; i < 40 && k < 4; i++) begin
            cycle(1'b1, 8'(k), 4'($urandom), hs);
            if (hs) begin
                if (last >= 0) begin
                    n_vec++;
                    if (cyc - last !== WL_PULSE + 3) begin
                        n_bad++;
                        $display("FAIL b2b_spacing got %0d want %0d", cyc - last, WL_PULSE + 3);
                    end
                end
                last = cyc;
                k++;
            end
        end
        repeat (WL_PULSE + 3) cycle(1'b0, 8'd0, 4'd0, hs);
        n_vec++;
        if (k !== 4 || wr_count !== 9'd4) begin
            n_bad++;
            $display("FAIL b2b_total got words=%0d cnt=%0d want 4/4", k, wr_count);
        end
    endtask

    task automatic test_addr_err();
        logic hs;
        do_reset();
        cycle(1'b1, 8'd7, 4'hF, hs);
        n_vec++;
        if (addr_err !== 1'b1 || busy !== 1'b0 || wl !== 4'b0 || wr_count !== 9'd0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_err_drop got err=%b busy=%b wl=%b cnt=%0d rdy=%b want 1/0/0000/0/1",
                     addr_err, busy, wl, wr_count, cfg_ready);
        end
        cycle(1'b1, 8'd1, 4'h5, hs);
        repeat (WL_PULSE + 3) cycle(1'b0, 8'd0, 4'd0, hs);
        n_vec++;
        if (addr_err !== 1'b1 || wr_count !== 9'd1) begin
            n_bad++;
            $display("FAIL addr_err_sticky got err=%b cnt=%0d want 1/1", addr_err, wr_count);
        end
    endtask

    task automatic test_reset_abort();
        logic hs;
        do_reset();
        cycle(1'b1, 8'd0, 4'h6, hs);
        repeat (WL_PULSE + 2) cycle(1'b0, 8'd0, 4'd0, hs);
        cycle(1'b1, 8'd3, 4'h9, hs);
        cycle(1'b0, 8'd0, 4'd0, hs);
        cycle(1'b0, 8'd0, 4'd0, hs);
        cycle(1'b0, 8'd0, 4'd0, hs);
        #2;
        prog_reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (wl !== 4'b0 || bl !== 4'b0 || busy !== 1'b0 || wr_count !== 9'd0) begin
            n_bad++;
            $display("FAIL abort_async got bl=%b wl=%b busy=%b cnt=%0d want 0/0/0/0", bl, wl, busy, wr_count);
        end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        #1;
        n_vec++;
        if (cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_ready got %b want 1", cfg_ready);
        end
        cycle(1'b0, 8'd0, 4'd0, hs);
    endtask

    task automatic test_random();
        logic hs;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)), 4'($urandom), hs);
        end
    endtask

    task automatic test_pulse1();
        int   last = -1;
        int   run = 0;
        int   n_hs = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            @(negedge prog_clk);
            c1_valid = 1'b1;
            c1_addr  = 8'd1;
            c1_data  = 4'hA;
            #1;
            if (c1_ready === 1'b1) begin
                if (last >= 0) begin
                    n_vec++;
                    if (i - last !== 4) begin
                        n_bad++;
                        $display("FAIL pulse1_period got %0d want 4", i - last);
                    end
                end
                last = i;
                n_hs++;
            end
            @(posedge prog_clk);
            #1;
            if (wl1 !== 4'b0000) begin
                run++;
                n_vec++;
                if (wl1 !== 4'b0010) begin
                    n_bad++;
                    $display("FAIL pulse1_wl got %b want 0010", wl1);
                end
            end else if (run != 0) begin
                n_vec++;
                if (run !== 1) begin
                    n_bad++;
                    $display("FAIL pulse1_width got %0d want 1", run);
                end
                run = 0;
            end
        end
        c1_valid = 1'b0;
        n_vec++;
        if (n_hs < 5) begin
            n_bad++;
            $display("FAIL pulse1_count got %0d handshakes want >=5", n_hs);
        end
    endtask

    task automatic test_saturation();
        logic hs;
        int   writes = 0;
        do_reset();
        for (int i = 0; i < 3000 && writes < 520; i++) begin
            cycle(1'b1, 8'($urandom_range(0, NUM_WL - 1)), 4'($urandom), hs);
            if (hs) writes++;
        end
        repeat (WL_PULSE + 3) cycle(1'b0, 8'd0, 4'd0, hs);
        n_vec++;
        if (writes !== 520 || wr_count !== 9'd511) begin
            n_bad++;
            $display("FAIL saturate got writes=%0d cnt=%0d want 520/511", writes, wr_count);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pulse1();
        test_single_write();
        test_back_to_back();
        test_addr_err();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
